// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and FSM encoding for the pipeline sequencer.
//   NREG          number of architectural registers
//   IDX_W         register index width
//   CNT_W         width of one scoreboard counter
//   MAX_INFLIGHT  deepest possible writer count per register (RR..WB)
package pipe_pkg;

    localparam int unsigned NREG         = 8;
    localparam int unsigned IDX_W        = 3;
    localparam int unsigned CNT_W        = 3;
    localparam int unsigned MAX_INFLIGHT = 4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_e;

endpackage

// File: rtl/pipe_sequencer_if.sv
// pipe_sequencer_if: pipeline-status inputs and pipeline-control outputs of
// the sequencer.
//   master : pipeline side, drives stage status, receives stall/flush/fetch.
//   slave  : sequencer side.
interface pipe_sequencer_if
    import pipe_pkg::*;
#(
    parameter int unsigned IDX_W = pipe_pkg::IDX_W
);

    // Decode stage
    logic             d_valid;
    logic             d_read1;
    logic             d_read2;
    logic [IDX_W-1:0] d_src1_idx;
    logic [IDX_W-1:0] d_src2_idx;
    logic             d_regwrite;
    logic [IDX_W-1:0] d_dst_idx;
    // RR stage
    logic             rr_valid;
    logic             rr_regwrite;
    logic [IDX_W-1:0] rr_dst_idx;
    // EX / MEM stages
    logic             e_valid;
    logic             e_is_jmp;
    logic             e_is_halt;
    logic             m_valid;
    // WB stage
    logic             wb_valid;
    logic             wb_regwrite;
    logic [IDX_W-1:0] wb_dst_idx;
    // Control back to the pipeline
    logic             stall_front;
    logic             bubble_rr;
    logic             flush_front;
    logic             fetch_en;
    logic             halted;
    logic [31:0]      stall_cycles;

    modport master (
        output d_valid, d_read1, d_read2, d_src1_idx, d_src2_idx,
               d_regwrite, d_dst_idx,
               rr_valid, rr_regwrite, rr_dst_idx,
               e_valid, e_is_jmp, e_is_halt, m_valid,
               wb_valid, wb_regwrite, wb_dst_idx,
        input  stall_front, bubble_rr, flush_front, fetch_en, halted,
               stall_cycles
    );

    modport slave (
        input  d_valid, d_read1, d_read2, d_src1_idx, d_src2_idx,
               d_regwrite, d_dst_idx,
               rr_valid, rr_regwrite, rr_dst_idx,
               e_valid, e_is_jmp, e_is_halt, m_valid,
               wb_valid, wb_regwrite, wb_dst_idx,
        output stall_front, bubble_rr, flush_front, fetch_en, halted,
               stall_cycles
    );

endinterface

// File: rtl/sb_counter.sv
// sb_counter: one scoreboard entry, counting in-flight writers of a register.
//   clk, rst   clock, asynchronous active-high reset
//   inc        a writer to this register issues from Decode
//   dec_wb     a writer to this register retires from WB
//   dec_fl     a writer to this register is killed in RR by a flush
//   count      current number of in-flight writers
// All three updates may land on the same edge; the net sum is applied.
module sb_counter
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W   = pipe_pkg::CNT_W,
    parameter int unsigned MAX_CNT = MAX_INFLIGHT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec_wb,
    input  logic             dec_fl,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned SUM_W = CNT_W + 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [SUM_W-1:0] up_sum;
    logic [SUM_W-1:0] dn_sum;
    logic [SUM_W-1:0] net_sum;
    logic             underflow;
    logic             overflow;

    // Net update; clamps keep the counter in range if the pipeline misbehaves
    always_comb begin
        up_sum    = {1'b0, count_q} + SUM_W'(inc);
        dn_sum    = SUM_W'(dec_wb) + SUM_W'(dec_fl);
        net_sum   = up_sum - dn_sum;
        underflow = up_sum < dn_sum;
        overflow  = !underflow && (net_sum > SUM_W'(MAX_CNT));
        count_d   = CNT_W'(net_sum);
        if (underflow) begin
            count_d = '0;
        end else if (overflow) begin
            count_d = CNT_W'(MAX_CNT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Simulation-only guard: a decrement from zero or a wrap is a pipeline bug
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_no_underflow: assert (!underflow);
            a_no_overflow:  assert (!overflow);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_sequencer.sv
// pipe_sequencer: hazard, flush and halt controller for the 6-stage pipeline.
//   clk, rst   pipeline clock, asynchronous active-high reset
//   bus        pipe_sequencer_if.slave
//              in : Decode sources/destination, RR/EX/MEM/WB status,
//                   EX jump and halt
//              out: stall_front, bubble_rr, flush_front, fetch_en, halted,
//                   stall_cycles
// Per-register scoreboard counters track writers in RR..WB; Decode stalls
// while any source has a pending writer not retiring this cycle.
module pipe_sequencer
    import pipe_pkg::*;
#(
    parameter int unsigned NREG  = pipe_pkg::NREG,
    parameter int unsigned IDX_W = pipe_pkg::IDX_W,
    parameter int unsigned CNT_W = pipe_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    pipe_sequencer_if.slave  bus
);

    logic [CNT_W-1:0] cnt [NREG];
    logic [NREG-1:0]  inc_v;
    logic [NREG-1:0]  dec_wb_v;
    logic [NREG-1:0]  dec_fl_v;

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [31:0]      stall_cycles_q;
    logic [31:0]      stall_cycles_d;

    logic             wb_ret;
    logic             src1_busy;
    logic             src2_busy;
    logic             hazard;
    logic             issue;
    logic             pipe_empty;
    logic             flush_front;
    logic             stall_front;
    logic             fetch_en;
    logic             halted;

    // Scoreboard: one counter per register plus its update decode
    for (genvar r = 0; r < NREG; r++) begin : g_sb
        assign inc_v[r]    = issue & bus.d_regwrite
                           & (bus.d_dst_idx == IDX_W'(r));
        assign dec_wb_v[r] = wb_ret & (bus.wb_dst_idx == IDX_W'(r));
        assign dec_fl_v[r] = flush_front & bus.rr_valid & bus.rr_regwrite
                           & (bus.rr_dst_idx == IDX_W'(r));

        sb_counter #(
            .CNT_W   (CNT_W),
            .MAX_CNT (MAX_INFLIGHT)
        ) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .inc    (inc_v[r]),
            .dec_wb (dec_wb_v[r]),
            .dec_fl (dec_fl_v[r]),
            .count  (cnt[r])
        );
    end

    // RAW hazard: a writer retiring in WB this cycle does not block, since
    // the register file write and the RR read happen on the same edge
    always_comb begin
        wb_ret    = bus.wb_valid & bus.wb_regwrite;
        src1_busy = cnt[bus.d_src1_idx]
                  > CNT_W'(wb_ret & (bus.wb_dst_idx == bus.d_src1_idx));
        src2_busy = cnt[bus.d_src2_idx]
                  > CNT_W'(wb_ret & (bus.wb_dst_idx == bus.d_src2_idx));
        hazard    = bus.d_valid & ((bus.d_read1 & src1_busy)
                                 | (bus.d_read2 & src2_busy));
        pipe_empty = ~(bus.rr_valid | bus.e_valid | bus.m_valid | bus.wb_valid);
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; HALTED is only left through reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (bus.e_is_halt) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    // FSM outputs; a flush always beats a stall. Forced idle while in reset.
    always_comb begin
        flush_front = 1'b0;
        stall_front = 1'b0;
        fetch_en    = 1'b1;
        halted      = 1'b0;
        issue       = 1'b0;
        if (!rst) begin
            flush_front = bus.e_is_jmp | ((state_q == ST_RUN) & bus.e_is_halt);
            stall_front = hazard & ~flush_front & (state_q == ST_RUN);
            fetch_en    = (state_q == ST_RUN) & ~bus.e_is_halt;
            halted      = state_q == ST_HALTED;
            issue       = bus.d_valid & ~hazard & ~flush_front
                        & (state_q == ST_RUN);
        end
    end

    // Saturating stall-cycle counter
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_front && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.stall_front  = stall_front;
    assign bus.bubble_rr    = stall_front;
    assign bus.flush_front  = flush_front;
    assign bus.fetch_en     = fetch_en;
    assign bus.halted       = halted;
    assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_sequencer.sv
// tb_pipe_sequencer: directed self-checking bench for pipe_sequencer.
// A four-slot shift model (RR, EX, MEM, WB) carries issued instructions so
// the back-end status inputs stay consistent with what the scoreboard saw.
module tb_pipe_sequencer;
    import pipe_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    // Back-end model: index 0=RR, 1=EX, 2=MEM, 3=WB
    logic       mv [4];
    logic       mw [4];
    logic [2:0] md [4];

    pipe_sequencer_if bus ();

    pipe_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.rr_valid    = mv[0];
        bus.rr_regwrite = mw[0];
        bus.rr_dst_idx  = md[0];
        bus.e_valid     = mv[1];
        bus.m_valid     = mv[2];
        bus.wb_valid    = mv[3];
        bus.wb_regwrite = mw[3];
        bus.wb_dst_idx  = md[3];
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            mv[i] = 1'b0;
            mw[i] = 1'b0;
            md[i] = 3'd0;
        end
        drive();
    endtask

    task automatic set_dec(input logic v, input logic r1, input logic [2:0] s1,
                           input logic r2, input logic [2:0] s2,
                           input logic wr, input logic [2:0] dst);
        bus.d_valid    = v;
        bus.d_read1    = r1;
        bus.d_src1_idx = s1;
        bus.d_read2    = r2;
        bus.d_src2_idx = s2;
        bus.d_regwrite = wr;
        bus.d_dst_idx  = dst;
        drive();
    endtask

    // Advance one edge; iss/fl are the hand-expected issue and flush
    task automatic tick(input logic iss, input logic fl);
        @(posedge clk);
        #1;
        for (int i = 3; i > 1; i--) begin
            mv[i] = mv[i-1];
            mw[i] = mw[i-1];
            md[i] = md[i-1];
        end
        mv[1] = mv[0] & ~fl;
        mw[1] = mw[0];
        md[1] = md[0];
        mv[0] = iss;
        mw[0] = iss & bus.d_regwrite;
        md[0] = bus.d_dst_idx;
        bus.e_is_jmp  = 1'b0;
        bus.e_is_halt = 1'b0;
        set_dec(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
    endtask

    task automatic idle();
        set_dec(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
        tick(1'b0, 1'b0);
    endtask

    function automatic int cnt_sum();
        int s;
        s = 0;
        for (int k = 0; k < 8; k++) begin
            s += int'(dut.cnt[k]);
        end
        return s;
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        clear_model();
        set_dec(1'b1, 1'b1, 3'd1, 1'b0, 3'd0, 1'b1, 3'd1);
        bus.e_is_jmp  = 1'b1;
        bus.e_is_halt = 1'b1;

        // Reset: outputs forced idle even with jump/halt asserted
        @(posedge clk);
        #1;
        chk("rst_stall",   32'(bus.stall_front), 32'd0);
        chk("rst_bubble",  32'(bus.bubble_rr), 32'd0);
        chk("rst_flush",   32'(bus.flush_front), 32'd0);
        chk("rst_fetch",   32'(bus.fetch_en), 32'd1);
        chk("rst_halted",  32'(bus.halted), 32'd0);
        chk("rst_stallcnt", bus.stall_cycles, 32'd0);
        chk("rst_state",   32'(dut.state_q), 32'(ST_RUN));
        chk("rst_cnt_sum", 32'(cnt_sum()), 32'd0);
        bus.e_is_jmp  = 1'b0;
        bus.e_is_halt = 1'b0;
        set_dec(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
        rst = 1'b0;

        // Back-to-back dependency on R1
        set_dec(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd1);
        #1;
        chk("b2b_first_nostall", 32'(bus.stall_front), 32'd0);
        tick(1'b1, 1'b0);
        chk("b2b_cnt1_up", 32'(dut.cnt[1]), 32'd1);
        for (int c = 0; c < 3; c++) begin
            set_dec(1'b1, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 3'd0);
            #1;
            chk("b2b_stall", 32'(bus.stall_front), 32'd1);
            chk("b2b_bubble", 32'(bus.bubble_rr), 32'd1);
            tick(1'b0, 1'b0);
        end
        set_dec(1'b1, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 3'd0);
        #1;
        chk("b2b_wb_release", 32'(bus.stall_front), 32'd0);
        tick(1'b1, 1'b0);
        chk("b2b_cnt1_down", 32'(dut.cnt[1]), 32'd0);
        chk("b2b_stallcnt", bus.stall_cycles, 32'd3);

        // Independent stream: src1 long retired, src2 retiring in WB
        for (int i = 0; i < 10; i++) begin
            set_dec(1'b1, 1'b1, 3'((i + 3) % 8), 1'b1, 3'((i + 4) % 8),
                    1'b1, 3'(i % 8));
            #1;
            chk("indep_nostall", 32'(bus.stall_front), 32'd0);
            tick(1'b1, 1'b0);
        end
        chk("indep_stallcnt", bus.stall_cycles, 32'd3);
        for (int c = 0; c < 4; c++) idle();
        chk("indep_drained", 32'(cnt_sum()), 32'd0);

        // Jump kill: jump in EX, writer to R2 in RR, Decode has a hazard
        set_dec(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
        tick(1'b1, 1'b0);
        set_dec(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd2);
        tick(1'b1, 1'b0);
        chk("jmp_cnt2_pre", 32'(dut.cnt[2]), 32'd1);
        set_dec(1'b1, 1'b1, 3'd2, 1'b0, 3'd0, 1'b1, 3'd4);
        bus.e_is_jmp = 1'b1;
        #1;
        chk("jmp_flush",  32'(bus.flush_front), 32'd1);
        chk("jmp_stall",  32'(bus.stall_front), 32'd0);
        chk("jmp_bubble", 32'(bus.bubble_rr), 32'd0);
        chk("jmp_fetch",  32'(bus.fetch_en), 32'd1);
        tick(1'b0, 1'b1);
        chk("jmp_cnt2_killed", 32'(dut.cnt[2]), 32'd0);
        chk("jmp_cnt4_noissue", 32'(dut.cnt[4]), 32'd0);
        chk("jmp_stallcnt", bus.stall_cycles, 32'd3);
        for (int c = 0; c < 4; c++) idle();

        // Same-edge collision on R3: issue while the old writer retires
        set_dec(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd3);
        tick(1'b1, 1'b0);
        chk("coll_cnt3_pre", 32'(dut.cnt[3]), 32'd1);
        for (int c = 0; c < 3; c++) idle();
        set_dec(1'b1, 1'b1, 3'd3, 1'b0, 3'd0, 1'b1, 3'd3);
        #1;
        chk("coll_nohazard", 32'(bus.stall_front), 32'd0);
        chk("coll_cnt3_wb", 32'(dut.cnt[3]), 32'd1);
        tick(1'b1, 1'b0);
        chk("coll_cnt3_post", 32'(dut.cnt[3]), 32'd1);
        for (int c = 0; c < 4; c++) idle();
        chk("coll_cnt3_drained", 32'(dut.cnt[3]), 32'd0);

        // Halt drain: Z(R0 writer), A, H, B(R7 writer) fill WB..RR
        set_dec(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd0);
        tick(1'b1, 1'b0);
        set_dec(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
        tick(1'b1, 1'b0);
        set_dec(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
        tick(1'b1, 1'b0);
        set_dec(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd7);
        tick(1'b1, 1'b0);
        chk("halt_cnt7_pre", 32'(dut.cnt[7]), 32'd1);
        set_dec(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
        bus.e_is_halt = 1'b1;
        #1;
        chk("halt_fetch_off", 32'(bus.fetch_en), 32'd0);
        chk("halt_flush",     32'(bus.flush_front), 32'd1);
        chk("halt_not_yet",   32'(bus.halted), 32'd0);
        tick(1'b0, 1'b1);
        chk("halt_state_drain", 32'(dut.state_q), 32'(ST_DRAIN));
        chk("halt_cnt7_killed", 32'(dut.cnt[7]), 32'd0);
        chk("halt_cnt0_retired", 32'(dut.cnt[0]), 32'd0);
        // Jump while draining still flushes but does not leave DRAIN
        set_dec(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
        bus.e_is_jmp = 1'b1;
        #1;
        chk("drain_jmp_flush", 32'(bus.flush_front), 32'd1);
        chk("drain_fetch_off", 32'(bus.fetch_en), 32'd0);
        tick(1'b0, 1'b1);
        chk("drain_state_1", 32'(dut.state_q), 32'(ST_DRAIN));
        #1;
        chk("drain_halted_0", 32'(bus.halted), 32'd0);
        idle();
        chk("drain_state_2", 32'(dut.state_q), 32'(ST_DRAIN));
        idle();
        chk("drain_halted", 32'(bus.halted), 32'd1);
        chk("drain_halted_fetch", 32'(bus.fetch_en), 32'd0);
        set_dec(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd1);
        #1;
        chk("halted_no_stall", 32'(bus.stall_front), 32'd0);
        tick(1'b0, 1'b0);
        chk("halted_no_issue", 32'(dut.cnt[1]), 32'd0);
        idle();
        chk("halted_held", 32'(bus.halted), 32'd1);

        // Async reset out of HALTED, then build cnt[5]=2 in DRAIN
        rst = 1'b1;
        #1;
        chk("rst1_halted", 32'(bus.halted), 32'd0);
        chk("rst1_fetch",  32'(bus.fetch_en), 32'd1);
        clear_model();
        rst = 1'b0;
        set_dec(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd5);
        tick(1'b1, 1'b0);
        set_dec(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd5);
        tick(1'b1, 1'b0);
        chk("r5_cnt2", 32'(dut.cnt[5]), 32'd2);
        idle();
        set_dec(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
        bus.e_is_halt = 1'b1;
        tick(1'b0, 1'b1);
        chk("r5_drain_state", 32'(dut.state_q), 32'(ST_DRAIN));
        chk("r5_drain_cnt", 32'(dut.cnt[5]), 32'd2);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_state",  32'(dut.state_q), 32'(ST_RUN));
        chk("arst_cnt5",   32'(dut.cnt[5]), 32'd0);
        chk("arst_cnt_sum", 32'(cnt_sum()), 32'd0);
        chk("arst_fetch",  32'(bus.fetch_en), 32'd1);
        chk("arst_halted", 32'(bus.halted), 32'd0);
        clear_model();
        rst = 1'b0;
        set_dec(1'b1, 1'b1, 3'd5, 1'b0, 3'd0, 1'b0, 3'd0);
        #1;
        chk("post_rst_nohazard", 32'(bus.stall_front), 32'd0);
        tick(1'b1, 1'b0);
        chk("post_rst_state", 32'(dut.state_q), 32'(ST_RUN));
        chk("post_rst_stallcnt", bus.stall_cycles, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
